// File: rtl/uart_tx_apb_feeder.sv
// rtl/uart_tx_apb_feeder.sv - APB master that queues bytes and writes them to a UART core's TX register.
// Define FEEDER_CFG_EN to program the core's baud registers after every reset.
module uart_tx_apb_feeder #(
    parameter int         DEPTH        = 8,
    parameter logic [7:0] BAUD_LO      = 8'h0D,
    parameter logic [7:0] BAUD_HI      = 8'h00,
    parameter int         GUARD_CYCLES = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [7:0]               IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic                     M_PSEL,
    output logic                     M_PENABLE,
    output logic [1:0]               M_PADDR,
    output logic                     M_PWRITE,
    output logic [7:0]               M_PWDATA,
    input  logic                     M_PREADY,
    input  logic                     TXRDY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     BUSY
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [AW:0]   full_level = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] guard_last = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        CFG_LO_S,
        CFG_LO_A,
        CFG_HI_S,
        CFG_HI_A,
        IDLE,
        TX_S,
        TX_A,
        TX_GUARD
    } state_t;

`ifdef FEEDER_CFG_EN
    localparam state_t reset_state = CFG_LO_S;
    localparam logic   reset_busy  = 1'b1;
`else
    localparam state_t reset_state = IDLE;
    localparam logic   reset_busy  = 1'b0;
`endif

    state_t          state;
    logic [GW-1:0]   guard_cnt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            push;
    logic            pop;

    assign IN_READY = (LEVEL != full_level);
    assign push     = IN_VALID && IN_READY;
    assign pop      = (state == TX_A) && M_PREADY;

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wptr] <= IN_DATA;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            LEVEL <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= reset_state;
            BUSY      <= reset_busy;
            guard_cnt <= '0;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PADDR   <= 2'b00;
            M_PWRITE  <= 1'b0;
            M_PWDATA  <= 8'h00;
        end else begin
            case (state)
                // Bus is idle out of reset, so the first edge only launches the setup phase.
                CFG_LO_S: begin
                    if (!M_PSEL) begin
                        M_PSEL   <= 1'b1;
                        M_PWRITE <= 1'b1;
                        M_PADDR  <= 2'b00;
                        M_PWDATA <= BAUD_LO;
                    end else begin
                        state     <= CFG_LO_A;
                        M_PENABLE <= 1'b1;
                    end
                end
                CFG_LO_A: begin
                    if (M_PREADY) begin
                        state     <= CFG_HI_S;
                        M_PENABLE <= 1'b0;
                        M_PADDR   <= 2'b01;
                        M_PWDATA  <= BAUD_HI;
                    end
                end
                CFG_HI_S: begin
                    state     <= CFG_HI_A;
                    M_PENABLE <= 1'b1;
                end
                CFG_HI_A: begin
                    if (M_PREADY) begin
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                        M_PSEL    <= 1'b0;
                        M_PENABLE <= 1'b0;
                        M_PWRITE  <= 1'b0;
                    end
                end
                IDLE: begin
                    if ((LEVEL != '0) && TXRDY) begin
                        state    <= TX_S;
                        BUSY     <= 1'b1;
                        M_PSEL   <= 1'b1;
                        M_PWRITE <= 1'b1;
                        M_PADDR  <= 2'b10;
                        M_PWDATA <= mem[rptr];
                    end
                end
                TX_S: begin
                    state     <= TX_A;
                    M_PENABLE <= 1'b1;
                end
                TX_A: begin
                    if (M_PREADY) begin
                        state     <= TX_GUARD;
                        guard_cnt <= '0;
                        M_PSEL    <= 1'b0;
                        M_PENABLE <= 1'b0;
                        M_PWRITE  <= 1'b0;
                    end
                end
                // Wait for the core to show it took the byte, so a stale TXRDY cannot relaunch.
                TX_GUARD: begin
                    if (!TXRDY || (guard_cnt == guard_last)) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
